// File: rtl/sync_fifo_gen2.sv
// Single-clock parametrised FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through; otherwise rd_data arrives 1 clk after rd_en.
module sync_fifo_gen2 #(
  parameter int DEPTH     = 16,
  parameter int D_WIDTH   = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [D_WIDTH-1:0]         wr_data,
  input  logic                       rd_en,
  output logic [D_WIDTH-1:0]         rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_THRESH);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, underflow_q;
  logic               wr_acc, rd_acc, mem_we;
`ifdef FIFO_FWFT_EN
  logic [AW:0]        mem_cnt;
  logic               mem_empty, stage_load;
`endif

  always_comb begin
`ifdef FIFO_FWFT_EN
    // The output register is one FIFO slot; it is empty only when memory is too.
    mem_cnt   = wr_ptr_q - rd_ptr_q;
    mem_empty = (mem_cnt == '0);
    count     = mem_cnt + (AW+1)'(rd_valid_q);
    empty     = !rd_valid_q;
    full      = (count == DEPTH_C);
`else
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
`endif
    wr_acc     = wr_en && !full;
    rd_acc     = rd_en && !empty;
    mem_we     = wr_acc;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
`ifdef FIFO_FWFT_EN
    stage_load = !rd_valid_q || rd_acc;
    if (stage_load) begin
      if (!mem_empty) begin
        rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end else if (wr_acc) begin
        // Write into an otherwise empty FIFO bypasses memory straight to the head.
        rd_data_d  = wr_data;
        rd_valid_d = 1'b1;
        mem_we     = 1'b0;
      end else begin
        rd_valid_d = 1'b0;
      end
    end
`else
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
`endif
    wr_ptr_d = wr_ptr_q + (AW+1)'(mem_we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_q | (wr_en && full);
      underflow_q <= underflow_q | (rd_en && empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Bench for sync_fifo_gen2: vector table, directed corner sequences, random traffic vs queue model.
module tb_sync_fifo_gen2;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_ovf, m_unf, m_vld;
  logic [7:0] m_dat;

  sync_fifo_gen2 #(.DEPTH(DEPTH), .D_WIDTH(8), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic [7:0] d, input logic rr);
    int sz;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0; m_dat = 8'h00;
    end else begin
      sz = mq.size();
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (rr && sz == 0)    m_unf = 1'b1;
`ifdef FIFO_FWFT_EN
      if (rr && sz > 0) void'(mq.pop_front());
      if (w && sz < DEPTH) mq.push_back(d);
      m_vld = (mq.size() > 0);
      if (m_vld) m_dat = mq[0];
`else
      if (rr && sz > 0) begin
        m_dat = mq.pop_front();
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (w && sz < DEPTH) mq.push_back(d);
`endif
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("m_count", 32'(count), 32'(sz));
    chk("m_full", 32'(full), 32'(sz == DEPTH));
    chk("m_empty", 32'(empty), 32'(sz == 0));
    chk("m_afull", 32'(almost_full), 32'(sz >= AF));
    chk("m_aempty", 32'(almost_empty), 32'(sz <= AE));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_unf", 32'(underflow), 32'(m_unf));
    chk("m_rd_valid", 32'(rd_valid), 32'(m_vld));
`ifdef FIFO_FWFT_EN
    if (m_vld) chk("m_rd_data", 32'(rd_data), 32'(m_dat));
`else
    chk("m_rd_data", 32'(rd_data), 32'(m_dat));
`endif
  endtask

  // Drive after a falling edge, commit at the rising edge, sample at the next falling edge.
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rr);
    reset = r; wr_en = w; wr_data = d; rd_en = rr;
    @(posedge clk);
    model_update(r, w, d, rr);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    int         cnt;
    logic       emp;
    logic       ae;
    logic       unf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int wp, rp;
    tbl[0] = '{1'b1, 8'hA1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'hB2, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'hC3, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'hD4, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].w, tbl[i].d, tbl[i].r);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].emp));
      chk("tbl_aempty", 32'(almost_empty), 32'(tbl[i].ae));
      chk("tbl_unf", 32'(underflow), 32'(tbl[i].unf));
    end

    // Fill to full, then one dropped write
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_count_hold", 32'(count), 32'd16);

    // Drain in order, then underflow
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      chk("drain_head", 32'(rd_data), 32'(i));
      chk("drain_vld", 32'(rd_valid), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
`else
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_data", 32'(rd_data), 32'(i));
      chk("drain_vld", 32'(rd_valid), 32'd1);
`endif
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_unf", 32'(underflow), 32'd1);
    chk("drain_vld_off", 32'(rd_valid), 32'd0);

    // Steady state at count 5 with pointer wrap
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 8'(8'h40 + k), 1'b1);
      chk("steady_count", 32'(count), 32'd5);
    end

    // Simultaneous request at full
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    chk("full_rw_count", 32'(count), 32'd15);
    chk("full_rw_ovf", 32'(overflow), 32'd1);
    chk("full_rw_full", 32'(full), 32'd0);

    // Reset mid-operation
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    chk("mid_count", 32'(count), 32'd9);
    chk("mid_unf_set", 32'(underflow), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_unf", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 8'h5C, 1'b0);
`ifdef FIFO_FWFT_EN
    chk("mid_fwft_data", 32'(rd_data), 32'h5C);
    chk("mid_fwft_vld", 32'(rd_valid), 32'd1);
`endif
    step(1'b0, 1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
    chk("mid_data", 32'(rd_data), 32'h5C);
    chk("mid_vld", 32'(rd_valid), 32'd1);
`endif
    chk("mid_empty_after", 32'(empty), 32'd1);

    // Random traffic with shifting bias so full and empty are both visited
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        wp = (n / 200) % 3 == 0 ? 85 : ((n / 200) % 3 == 1 ? 50 : 15);
        rp = 100 - wp;
      end
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < wp),
           8'($urandom), ($urandom_range(0, 99) < rp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
